// File: rtl/zfsoc_pio_pkg.sv
// Shared register map and bus constants for the zfsoc PIO slaves.
// Pure declarations; no logic, no latency, no flow control.
package zfsoc_pio_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;

   localparam logic [ADDR_W-1:0] ADDR_DATA         = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK   = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_BLINK_PERIOD = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_OUTSET       = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR     = 3'd5;

endpackage

// File: rtl/zfsoc_blink_timer.sv
// Blink half-period down-counter and phase toggle for the LED PIO.
// phase_o is the next-state phase (value held after the coming edge); no backpressure.
module zfsoc_blink_timer
   import zfsoc_pio_pkg::*;
#(
   parameter int PERIOD_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PERIOD_WIDTH-1:0] period_i,
   input  logic                    load_i,
   output logic                    phase_o
);

   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic                    phase_q, phase_d;

   // period_i is the period that will be in force after this edge, so a
   // reload and a zero period share the same restart path.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (load_i || (period_i == '0)) begin
         cnt_d   = (period_i == '0) ? '0 : period_i - 1'b1;
         phase_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d   = period_i - 1'b1;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_o = phase_d;

endmodule

// File: rtl/zfsoc_led_pio.sv
// Avalon-MM output PIO: DATA with set/clear aliases; blink engine under ZFSOC_LED_PIO_BLINK_EN.
// Write to pins 1 cycle, read latency 1 cycle; no wait states or backpressure.
module zfsoc_led_pio
   import zfsoc_pio_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
   parameter int               PERIOD_WIDTH = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic [WIDTH-1:0]  out_port
);

   logic             wr_en;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   assign wr_en     = chipselect && !write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   logic [WIDTH-1:0]  data_q, data_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic [DATA_W-1:0] rd_q, rd_d;

   always_comb begin
      data_d = data_q;
      if (wr_en) begin
         case (address)
            ADDR_DATA:     data_d = wd;
            ADDR_OUTSET:   data_d = data_q | wd;
            ADDR_OUTCLEAR: data_d = data_q & ~wd;
            default:       data_d = data_q;
         endcase
      end
   end

`ifdef ZFSOC_LED_PIO_BLINK_EN
   logic [WIDTH-1:0]        mask_q, mask_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic                    period_load;
   logic                    phase_nxt;

   assign period_load = wr_en && (address == ADDR_BLINK_PERIOD);

   always_comb begin
      mask_d   = mask_q;
      period_d = period_q;
      if (wr_en && (address == ADDR_BLINK_MASK)) mask_d = wd;
      if (period_load) period_d = writedata[PERIOD_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q   <= '0;
         period_q <= '0;
      end else begin
         mask_q   <= mask_d;
         period_q <= period_d;
      end
   end

   zfsoc_blink_timer #(
      .PERIOD_WIDTH(PERIOD_WIDTH)
   ) u_blink_timer (
      .clk     (clk),
      .reset   (reset),
      .period_i(period_d),
      .load_i  (period_load),
      .phase_o (phase_nxt)
   );

   // Gate with next-state values so a DATA write and a toggle on the same edge both land.
   assign out_d = data_d & ~(mask_d & {WIDTH{phase_nxt}});
`else
   assign out_d = data_d;
`endif

   always_comb begin
      rd_d = '0;
      case (address)
         ADDR_DATA:         rd_d[WIDTH-1:0] = data_q;
`ifdef ZFSOC_LED_PIO_BLINK_EN
         ADDR_BLINK_MASK:   rd_d[WIDTH-1:0] = mask_q;
         ADDR_BLINK_PERIOD: rd_d[PERIOD_WIDTH-1:0] = period_q;
`endif
         default:           rd_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= RESET_VALUE;
         out_q  <= RESET_VALUE;
         rd_q   <= '0;
      end else begin
         data_q <= data_d;
         out_q  <= out_d;
         rd_q   <= rd_d;
      end
   end

   assign readdata = rd_q;
   assign out_port = out_q;

endmodule

// File: tb/tb_zfsoc_led_pio.sv
// Bench for zfsoc_led_pio: directed plan steps plus random bus traffic against a timeline model.
module tb_zfsoc_led_pio;

   localparam logic [7:0] RV = 8'hA5;
`ifdef ZFSOC_LED_PIO_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   always #5 clk = ~clk;

   zfsoc_led_pio #(
      .WIDTH(8),
      .RESET_VALUE(RV),
      .PERIOD_WIDTH(24)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .out_port  (out_port)
   );

   int          total = 0;
   int          bad   = 0;
   longint      edge_n = 0;
   longint      w_edge = 0;
   logic [7:0]  m_data = RV;
   logic [7:0]  m_mask = '0;
   logic [23:0] m_per  = '0;
   logic [31:0] m_rd   = '0;
   logic [7:0]  m_out  = RV;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Phase is the parity of whole half-periods elapsed since the last period write.
   function automatic bit m_phase();
      if (m_per == 0) return 1'b0;
      return (((edge_n - w_edge) / longint'(m_per)) % 2) == 1;
   endfunction

   task automatic step(input string tag, input bit rst, input bit cs, input bit wn,
                       input logic [2:0] a, input logic [31:0] wd);
      logic [31:0] rd_n;
      reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
      rd_n = '0;
      case (a)
         3'd0: rd_n = {24'd0, m_data};
         3'd1: if (BLINK) rd_n = {24'd0, m_mask};
         3'd2: if (BLINK) rd_n = {8'd0, m_per};
         default: rd_n = '0;
      endcase
      @(posedge clk);
      edge_n++;
      if (rst) begin
         m_data = RV; m_mask = '0; m_per = '0; m_rd = '0;
      end else begin
         m_rd = rd_n;
         if (cs && !wn) begin
            case (a)
               3'd0: m_data = wd[7:0];
               3'd1: if (BLINK) m_mask = wd[7:0];
               3'd2: if (BLINK) begin m_per = wd[23:0]; w_edge = edge_n; end
               3'd4: m_data = m_data | wd[7:0];
               3'd5: m_data = m_data & ~wd[7:0];
               default: ;
            endcase
         end
      end
      m_out = m_data & ~(m_mask & {8{m_phase()}});
      #1;
      chk({tag, "_out"}, {24'd0, out_port}, {24'd0, m_out});
      chk({tag, "_rd"}, readdata, m_rd);
   endtask

   task automatic wr(input string tag, input logic [2:0] a, input logic [31:0] wd);
      step(tag, 1'b0, 1'b1, 1'b0, a, wd);
   endtask

   task automatic rd(input string tag, input logic [2:0] a);
      step(tag, 1'b0, 1'b0, 1'b1, a, 32'd0);
   endtask

   initial begin
      step("rst", 1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      step("rst", 1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      chk("rst_pins", {24'd0, out_port}, 32'hA5);
      chk("rst_rdata", readdata, 32'd0);
      rd("rd_data", 3'd0);
      chk("rd_data_lit", readdata, 32'hA5);

      wr("wr_data", 3'd0, 32'h3C);
      chk("data_lit", {24'd0, out_port}, 32'h3C);
      wr("outset", 3'd4, 32'h01);
      chk("outset_lit", {24'd0, out_port}, 32'h3D);
      wr("outclr", 3'd5, 32'h0C);
      chk("outclr_lit", {24'd0, out_port}, 32'h31);
      rd("rd_set", 3'd4);
      chk("rd_set_lit", readdata, 32'd0);
      rd("rd_clr", 3'd5);
      chk("rd_clr_lit", readdata, 32'd0);

      wr("bl_data", 3'd0, 32'hFF);
      wr("bl_mask", 3'd1, 32'h0F);
      wr("bl_per", 3'd2, 32'd3);
      for (int i = 0; i < 3; i++) rd("bl_idle", 3'd2);
      chk("blink_p3", {24'd0, out_port}, BLINK ? 32'hF0 : 32'hFF);
      for (int i = 0; i < 12; i++) rd("bl_run", 3'd1);

      wr("per0", 3'd2, 32'd0);
      chk("per0_lit", {24'd0, out_port}, 32'hFF);
      for (int i = 0; i < 4; i++) rd("per0_idle", 3'd0);
      wr("per1", 3'd2, 32'd1);
      for (int i = 0; i < 6; i++) rd("per1_run", 3'd0);

      wr("mb_per", 3'd2, 32'd2);
`ifdef ZFSOC_LED_PIO_BLINK_EN
      for (int i = 0; i < 10 && out_port !== 8'hF0; i++) rd("mb_wait", 3'd0);
      chk("mb_phase1", {24'd0, out_port}, 32'hF0);
`endif
      step("mb_rst", 1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      chk("mb_rst_lit", {24'd0, out_port}, 32'hA5);
      for (int i = 0; i < 6; i++) rd("mb_hold", 3'd2);

      wr("nb_per", 3'd2, 32'd5);
      wr("nb_mask", 3'd1, 32'hFF);
      rd("nb_rd2", 3'd2);
      rd("nb_rd1", 3'd1);

      for (int i = 0; i < 800; i++) begin
         logic [2:0]  a;
         logic [31:0] d;
         a = 3'($urandom_range(0, 7));
         d = (a == 3'd2) ? 32'($urandom_range(0, 6)) : $urandom;
         step("rnd", ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 2) == 0), a, d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
